hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Central pipeline control for the 5-stage core.
- Drives the stall/bubble inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the PC stall.
- Resolves three hazard classes:
  - multi-cycle data-memory wait, via a req/ready handshake;
  - load-use hazard;
  - EX-stage control-flow redirect.
- Keeps a wait FSM, a memory-timeout watchdog, and stall/flush performance counters.

Parameters:
- MEM_TIMEOUT, 64: cycles of continuous memory wait before mem_err is raised.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- rs1_id  input  5  source register 1 of the instruction in ID.
- rs2_id  input  5  source register 2 of the instruction in ID.
- rs1_used_id  input  1  ID instruction reads rs1.
- rs2_used_id  input  1  ID instruction reads rs2.
- rd_ex  input  5  destination register of the instruction in EX.
- mem_read_ex  input  1  EX instruction is a load.
- reg_write_ex  input  1  EX instruction writes the register file.
- redirect_ex  input  1  EX resolved a taken branch/jump or mispredict.
- mem_req_mem  input  1  MEM-stage instruction accesses data memory.
- mem_ready  input  1  data memory completes the access this cycle.
- stall_if  output  1  hold PC.
- stall_id  output  1  hold IF/ID.
- stall_ex  output  1  hold ID/EX.
- stall_mem  output  1  hold EX/MEM.
- stall_wb  output  1  hold MEM/WB.
- bubble_id  output  1  clear IF/ID to NOP.
- bubble_ex  output  1  clear ID/EX to NOP.
- bubble_mem  output  1  clear EX/MEM to NOP.
- bubble_wb  output  1  clear MEM/WB to NOP.
- mem_err  output  1  sticky memory-timeout flag.
- stall_cnt  output  CNT_W  cycles with stall_if asserted.
- flush_cnt  output  CNT_W  number of redirect flushes.

Behaviour:
- Combinational terms:
  - mem_busy = mem_req_mem & ~mem_ready.
  - load_use = mem_read_ex & reg_write_ex & (rd_ex != 0) & ((rs1_used_id & rs1_id == rd_ex) | (rs2_used_id & rs2_id == rd_ex)).
- Control outputs are combinational from the current inputs and are sampled by the pipeline registers at the same edge.
- Priority, highest first; exactly one case applies per cycle:
  1. mem_busy:
     - stall_if, stall_id, stall_ex, stall_mem = 1.
     - bubble_wb = 1, so no duplicate writeback occurs.
     - All other outputs 0.
     - redirect_ex and load_use are ignored. Their source instructions are frozen, so they are re-evaluated after release.
  2. redirect_ex:
     - bubble_id = 1 and bubble_ex = 1 (squash two wrong-path instructions).
     - All stalls 0; the PC loads the target.
  3. load_use:
     - stall_if = 1 and stall_id = 1.
     - bubble_ex = 1 (one-cycle bubble).
  4. Otherwise all control outputs are 0.
- redirect_ex and load_use cannot truly coexist, since a load never redirects; rule 2 still wins if both are asserted.
- bubble_mem and stall_wb are always 0 in this revision; the ports are kept for future exceptions.
- FSM states: RUN, MEM_WAIT.
  - RUN -> MEM_WAIT when mem_busy.
  - MEM_WAIT -> RUN when mem_ready or ~mem_req_mem.
  - MEM_WAIT -> MEM_WAIT otherwise.
  - The FSM itself does not gate outputs; it only drives the watchdog.
- Watchdog:
  - wait_cnt clears on entering MEM_WAIT and increments each cycle in MEM_WAIT.
  - When wait_cnt reaches MEM_TIMEOUT-1 while still busy, mem_err sets.
  - mem_err stays set until rst; wait_cnt saturates.
- Counters:
  - stall_cnt increments on every cycle with stall_if = 1.
  - flush_cnt increments on every cycle where rule 2 fires.
  - Both wrap modulo 2^CNT_W.
- Reset (asynchronous, any time, including mid-MEM_WAIT):
  - state = RUN; wait_cnt, mem_err, stall_cnt and flush_cnt = 0.
  - Combinational outputs follow the inputs immediately; the pipeline registers are themselves reset.
- Zero-cycle memory (mem_ready high with mem_req_mem): no stall, FSM stays in RUN.

Test Plan:
- Load-use: mem_read_ex = 1, reg_write_ex = 1, rd_ex = 5, rs1_id = 5, rs1_used_id = 1 -> stall_if = stall_id = bubble_ex = 1 for 1 cycle; stall_cnt = 1. Repeat with rd_ex = 0 -> no stall. Repeat with rs1_used_id = 0 -> no stall.
- Redirect: redirect_ex pulsed 1 cycle -> bubble_id = bubble_ex = 1, no stalls, flush_cnt = 1. Three pulses -> flush_cnt = 3.
- Memory wait: mem_req_mem = 1 with mem_ready low for 4 cycles then high -> stall_if..stall_mem = 1 and bubble_wb = 1 for exactly 4 cycles, FSM back in RUN, stall_cnt = 4, mem_err = 0.
- Priority: mem_busy and redirect_ex both high for 2 cycles, then mem_ready -> the 2 cycles show stall-only behaviour; the release cycle shows bubble_id = bubble_ex; flush_cnt = 1.
- Timeout with MEM_TIMEOUT = 8: mem_ready held low for 10 cycles -> mem_err rises in wait cycle 8 and stays high after mem_ready; async rst pulse mid-wait -> mem_err = 0 and counters = 0 immediately.
- Zero-wait access: mem_req_mem = mem_ready = 1 for 5 cycles -> all outputs 0, stall_cnt unchanged.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control for the 5-stage core: stall/bubble steering for memory waits,
// load-use hazards and EX redirects, plus a memory-wait watchdog and stall/flush counters.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             rs1_used_id,
  input  logic             rs2_used_id,
  input  logic [4:0]       rd_ex,
  input  logic             mem_read_ex,
  input  logic             reg_write_ex,
  input  logic             redirect_ex,
  input  logic             mem_req_mem,
  input  logic             mem_ready,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             stall_wb,
  output logic             bubble_id,
  output logic             bubble_ex,
  output logic             bubble_mem,
  output logic             bubble_wb,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WC_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT - 1);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [WC_W-1:0]   wait_cnt_r;
  logic              mem_err_r;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic [CNT_W-1:0]  flush_cnt_r;

  logic mem_busy_s;
  logic rs1_hit_s;
  logic rs2_hit_s;
  logic load_use_s;
  logic flush_fire_s;

  assign mem_busy_s   = mem_req_mem & ~mem_ready;
  assign rs1_hit_s    = rs1_used_id & (rs1_id == rd_ex);
  assign rs2_hit_s    = rs2_used_id & (rs2_id == rd_ex);
  assign load_use_s   = mem_read_ex & reg_write_ex & (rd_ex != 5'd0) & (rs1_hit_s | rs2_hit_s);
  // A memory wait freezes the redirecting instruction, so the flush only counts once released.
  assign flush_fire_s = redirect_ex & ~mem_busy_s;

  // Prioritised stall/bubble steering: memory wait, then redirect, then load-use.
  always_comb begin
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    stall_ex   = 1'b0;
    stall_mem  = 1'b0;
    stall_wb   = 1'b0;
    bubble_id  = 1'b0;
    bubble_ex  = 1'b0;
    bubble_mem = 1'b0;
    bubble_wb  = 1'b0;
    if (mem_busy_s) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      stall_mem = 1'b1;
      bubble_wb = 1'b1;
    end else if (redirect_ex) begin
      bubble_id = 1'b1;
      bubble_ex = 1'b1;
    end else if (load_use_s) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      bubble_ex = 1'b1;
    end else begin
      stall_if  = 1'b0;
      bubble_ex = 1'b0;
    end
  end

  // Wait FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      RUN: begin
        if (mem_busy_s) state_next_s = MEM_WAIT;
        else            state_next_s = RUN;
      end
      MEM_WAIT: begin
        if (!mem_busy_s) state_next_s = RUN;
        else             state_next_s = MEM_WAIT;
      end
      default: state_next_s = RUN;
    endcase
  end

  // Wait FSM state register and memory-timeout watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= RUN;
      wait_cnt_r <= {WC_W{1'b0}};
      mem_err_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (state_r == RUN) begin
        if (mem_busy_s) wait_cnt_r <= {WC_W{1'b0}};
        else            wait_cnt_r <= wait_cnt_r;
      end else begin
        if (wait_cnt_r != WC_MAX) wait_cnt_r <= wait_cnt_r + WC_W'(1'b1);
        else                      wait_cnt_r <= wait_cnt_r;
        if (mem_busy_s && (wait_cnt_r == WC_MAX)) mem_err_r <= 1'b1;
        else                                     mem_err_r <= mem_err_r;
      end
    end
  end

  // Performance counters; both wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_if) stall_cnt_r <= stall_cnt_r + CNT_W'(1'b1);
      else          stall_cnt_r <= stall_cnt_r;
      if (flush_fire_s) flush_cnt_r <= flush_cnt_r + CNT_W'(1'b1);
      else              flush_cnt_r <= flush_cnt_r;
    end
  end

  assign mem_err   = mem_err_r;
  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;

endmodule
